sp_byte_ram: RTL and testbench
==============================

// Module: sp_byte_ram
// PURPOSE
// - Byte-addressable single-port synchronous RAM with a valid/ready request handshake.
// - Each accepted request reads or writes one DATA_W-bit word starting at any byte address (little-endian).
// - Sits behind the ram_inf interface as the memory DUT.
// - No pipelining beyond one registered read stage.
// PARAMETERS
// - DATA_W  32   word width in bits; must be a multiple of 8; NB = DATA_W/8 bytes per access
// - ADDR_W  8    byte-address width; DEPTH = 2**ADDR_W bytes of storage
// PORTS
// - clk    in   1       single clock; all logic on rising edge
// - rst    in   1       reset, synchronous, active-low (asserted when 0)
// - valid  in   1       requester has a request on din/addr/wr_rd
// - ready  out  1       RAM can accept a request this cycle
// - wr_rd  in   1       1 = write, 0 = read
// - addr   in   ADDR_W  byte address of the lowest byte of the word
// - din    in   DATA_W  write data; din[8k+7:8k] goes to byte addr+k
// - dout   out  DATA_W  read data, registered
// BEHAVIOUR
// - Reset (rst==0 at a rising edge):
//   - ready<=0 and dout<=0.
//   - Any request presented while rst==0 is ignored.
//   - Memory contents: see CONFIGURATION.
// - ready
//   - Goes 1 on the first rising edge with rst==1.
//   - Stays 1 until the next reset; there is no busy state.
// - Accept: a request is accepted at a rising edge where valid && ready && rst==1.
//   - Back-to-back requests are accepted every cycle.
// - Write accepted: for k in 0..NB-1, mem[(addr+k) mod DEPTH] <= din[8k+:8].
//   - Contents are visible to any later read.
//   - dout is unchanged.
// - Read accepted: dout <= {mem[(addr+NB-1) mod DEPTH], ..., mem[addr]}.
//   - Valid from the edge after acceptance (1-cycle latency).
//   - dout holds until the next accepted read or reset.
// - Wrap-around: byte addresses wrap modulo DEPTH.
//   - Example: DEPTH=256, addr=8'hFE touches bytes FE, FF, 00, 01.
// - Read of a never-written byte returns 8'h00 with RAM_INIT_CLEAR_EN, X otherwise.
// - valid==0, or a cycle with ready==0: no memory or dout change.
// - Reset mid-operation: reset wins over a simultaneous request; no write occurs in a reset cycle.
// CONFIGURATION
// - Macro RAM_INIT_CLEAR_EN.
// - Defined: the reset cycle also clears every memory byte to 8'h00.
// - Undefined:
//   - Memory is not touched by reset; contents survive reset.
//   - Memory is uninitialised (X) at time 0.
//   - Memory may then map to block RAM.
// STRUCTURE
// - Package ram_pkg holds:
//   - localparams DATA_W, ADDR_W, NB, DEPTH
//   - typedefs data_t (logic [DATA_W-1:0]), addr_t (logic [ADDR_W-1:0]), byte_t (logic [7:0])
//   - enum op_e {OP_READ=1'b0, OP_WRITE=1'b1} for wr_rd
// - Single flat module with a byte array mem[DEPTH] and a generate loop over NB byte lanes.
// - No sub-module.
// - Interface ram_inf(clk,rst) bundles valid, ready, wr_rd, addr, din, dout.
// TESTING
// - Reset:
//   - Hold rst=0 for 2 cycles with valid=1, wr_rd=1 -> ready==0, dout==0, no write.
//   - Release rst -> ready==1 on next edge.
// - Aligned write then read:
//   - Write addr=8'h10, din=32'hDEADBEEF, then read addr=8'h10 -> dout==32'hDEADBEEF one cycle after read acceptance.
//   - Read addr=8'h11 -> dout==32'hxxDEADBE (with RAM_INIT_CLEAR_EN: 32'h00DEADBE).
// - Wrap-around: write addr=8'hFE, din=32'h44332211 -> mem[FE]=11, mem[FF]=22, mem[00]=33, mem[01]=44; read addr=8'h00 low half ==16'h4433.
// - Back-to-back: valid held 1 for writes to 0x20/0x24 then reads 0x20/0x24 on consecutive cycles -> all accepted, dout sequence matches, no stall.
// - Idle/hold: valid=0 with random addr/din for 5 cycles -> memory and dout unchanged.
// - RAM_INIT_CLEAR_EN:
//   - Write addr=0, then pulse reset, then read addr=0 -> 32'h0 if defined, previous data if undefined.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and sizing for the byte-addressable single-port RAM.
// Build with RAM_INIT_CLEAR_EN defined to zero all memory on reset.
package ram_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [7:0]        byte_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;
endpackage

// File: rtl/ram_inf.sv
// Request/response bundle between a requester and sp_byte_ram.
// Memory clearing on reset is selected by RAM_INIT_CLEAR_EN.
interface ram_inf (
  input logic clk,
  input logic rst
);
  import ram_pkg::*;

  logic  valid;
  logic  ready;
  logic  wr_rd;
  addr_t addr;
  data_t din;
  data_t dout;

  modport ram (
    input  clk, rst, valid, wr_rd, addr, din,
    output ready, dout
  );

  modport req (
    input  clk, rst, ready, dout,
    output valid, wr_rd, addr, din
  );
endinterface

// File: rtl/sp_byte_ram.sv
// Byte-addressable single-port RAM, little-endian words, 1-cycle read.
// RAM_INIT_CLEAR_EN: reset also clears every byte; otherwise memory keeps state.
module sp_byte_ram
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  output logic              ready,
  input  logic              wr_rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  byte_t mem_q [DEPTH];
  logic  ready_q, ready_d;
  data_t dout_q, dout_d;
  logic  acc, do_wr, do_rd;
  addr_t lane_addr [NB];
  data_t rd_word;

  // Each lane owns one byte of the word; addresses wrap at DEPTH.
  genvar k;
  generate
    for (k = 0; k < NB; k++) begin : g_lane
      assign lane_addr[k] = addr + addr_t'(k);
      assign rd_word[8*k +: 8] = mem_q[lane_addr[k]];
    end
  endgenerate

  always_comb begin
    acc     = valid && ready_q;
    do_wr   = acc && (op_e'(wr_rd) == OP_WRITE);
    do_rd   = acc && (op_e'(wr_rd) == OP_READ);
    ready_d = 1'b1;
    dout_d  = dout_q;
    if (do_rd) dout_d = rd_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      ready_q <= ready_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
`ifdef RAM_INIT_CLEAR_EN
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_wr) begin
      for (int j = 0; j < NB; j++) mem_q[lane_addr[j]] <= din[8*j +: 8];
    end
`else
    if (rst && do_wr) begin
      for (int j = 0; j < NB; j++) mem_q[lane_addr[j]] <= din[8*j +: 8];
    end
`endif
  end

  assign ready = ready_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_sp_byte_ram.sv
// Randomised self-checking bench for sp_byte_ram against a byte-array model.
// Honours RAM_INIT_CLEAR_EN for reset-clear expectations.
module tb_sp_byte_ram;
  import ram_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  valid = 1'b0;
  logic  wr_rd = 1'b0;
  addr_t addr = '0;
  data_t din = '0;
  logic  ready;
  data_t dout;

  int checks = 0;
  int errors = 0;

  byte_t m_mem [DEPTH];
  bit    m_known [DEPTH];
  logic  e_ready = 1'b0;
  data_t e_dout = '0;
  data_t e_mask = '1;

  always #5 clk = ~clk;

  sp_byte_ram dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .ready (ready),
    .wr_rd (wr_rd),
    .addr  (addr),
    .din   (din),
    .dout  (dout)
  );

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic v, input logic w,
                      input addr_t a, input data_t d);
    addr_t idx;
    rst = r; valid = v; wr_rd = w; addr = a; din = d;
    @(posedge clk);
    if (!r) begin
      e_ready = 1'b0;
      e_dout  = '0;
      e_mask  = '1;
`ifdef RAM_INIT_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = 8'h00;
        m_known[i] = 1'b1;
      end
`endif
    end else begin
      if (v && e_ready) begin
        for (int j = 0; j < NB; j++) begin
          idx = a + addr_t'(j);
          if (w) begin
            m_mem[idx] = d[8*j +: 8];
            m_known[idx] = 1'b1;
          end else begin
            e_dout[8*j +: 8] = m_mem[idx];
            e_mask[8*j +: 8] = m_known[idx] ? 8'hFF : 8'h00;
          end
        end
      end
      e_ready = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b1, 1'b1, 8'h40, $urandom);
      checks++;
      if (ready !== 1'b0 || dout !== '0) begin
        errors++;
        $display("FAIL reset_hold got ready=%b dout=%h want ready=0 dout=0",
                 ready, dout);
      end
    end
    step(1'b1, 1'b0, 1'b0, '0, '0);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got ready=%b want 1", ready);
    end
  endtask

  task automatic test_aligned();
    step(1'b1, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    step(1'b1, 1'b1, 1'b0, 8'h10, $urandom);
    checks++;
    if (dout !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL aligned_read got %h want deadbeef", dout);
    end
    step(1'b1, 1'b1, 1'b0, 8'h11, '0);
    checks++;
`ifdef RAM_INIT_CLEAR_EN
    if (dout !== 32'h00DEADBE) begin
      errors++;
      $display("FAIL offset_read got %h want 00deadbe", dout);
    end
`else
    if (dout[23:0] !== 24'hDEADBE) begin
      errors++;
      $display("FAIL offset_read got %h want xxdeadbe", dout);
    end
`endif
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b1, 1'b1, 8'hFE, 32'h44332211);
    step(1'b1, 1'b1, 1'b0, 8'h00, '0);
    checks++;
    if (dout[15:0] !== 16'h4433) begin
      errors++;
      $display("FAIL wrap_low got %h want 4433", dout[15:0]);
    end
    step(1'b1, 1'b1, 1'b0, 8'hFE, '0);
    checks++;
    if (dout !== 32'h44332211) begin
      errors++;
      $display("FAIL wrap_full got %h want 44332211", dout);
    end
  endtask

  task automatic test_back_to_back();
    data_t w0, w1;
    w0 = $urandom;
    w1 = $urandom;
    step(1'b1, 1'b1, 1'b1, 8'h20, w0);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got %b want 1", ready);
    end
    step(1'b1, 1'b1, 1'b1, 8'h24, w1);
    step(1'b1, 1'b1, 1'b0, 8'h20, '0);
    checks++;
    if (dout !== w0) begin
      errors++;
      $display("FAIL b2b_read0 got %h want %h", dout, w0);
    end
    step(1'b1, 1'b1, 1'b0, 8'h24, '0);
    checks++;
    if (dout !== w1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_read1 got %h rdy=%b want %h rdy=1",
               dout, ready, w1);
    end
  endtask

  task automatic test_idle();
    data_t held, snap;
    held = dout;
    snap = {m_mem[8'h23], m_mem[8'h22], m_mem[8'h21], m_mem[8'h20]};
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0, 1'($urandom), addr_t'($urandom), $urandom);
      checks++;
      if (dout !== held) begin
        errors++;
        $display("FAIL idle_hold got %h want %h", dout, held);
      end
    end
    step(1'b1, 1'b1, 1'b0, 8'h20, '0);
    checks++;
    if (dout !== snap) begin
      errors++;
      $display("FAIL idle_mem got %h want %h", dout, snap);
    end
  endtask

  task automatic test_reset_persist();
    data_t keep;
    keep = $urandom;
    step(1'b1, 1'b1, 1'b1, 8'h00, keep);
    step(1'b0, 1'b1, 1'b1, 8'h00, ~keep);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 8'h00, '0);
    checks++;
`ifdef RAM_INIT_CLEAR_EN
    if (dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_clear got %h want 0", dout);
    end
`else
    if (dout !== keep) begin
      errors++;
      $display("FAIL reset_keep got %h want %h", dout, keep);
    end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(1'b1, ($urandom_range(3, 0) != 0), 1'($urandom),
           addr_t'($urandom), $urandom);
      checks++;
      if ((dout & e_mask) !== (e_dout & e_mask) || ready !== e_ready) begin
        errors++;
        $display("FAIL random_%0d got %h rdy=%b want %h mask=%h rdy=%b",
                 c, dout, ready, e_dout, e_mask, e_ready);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 8'h00;
      m_known[i] = 1'b0;
    end
    #1;
    test_reset();
    test_aligned();
    test_wrap();
    test_back_to_back();
    test_idle();
    test_reset_persist();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
